// File: rtl/axis_eth_ptp_ts_capture.sv
// TX-side PTP timestamp capture: passes AXI-stream frames through and queues one
// {ts, tag, byte length, error} record per frame into a first-word fall-through FIFO.
module axis_eth_ptp_ts_capture #(
    parameter int DATA_WIDTH    = 64,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int PTP_TS_WIDTH  = 96,
    parameter int PTP_TAG_WIDTH = 16,
    parameter int USER_WIDTH    = PTP_TAG_WIDTH + 1,
    parameter int TS_FIFO_DEPTH = 4,
    parameter int FULL_MODE     = 0
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic [USER_WIDTH-1:0]    s_axis_tuser,

    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [USER_WIDTH-1:0]    m_axis_tuser,

    input  logic [PTP_TS_WIDTH-1:0]  ptp_time,

    output logic [PTP_TS_WIDTH-1:0]  m_axis_ts,
    output logic [PTP_TAG_WIDTH-1:0] m_axis_ts_tag,
    output logic [15:0]              m_axis_ts_len,
    output logic                     m_axis_ts_err,
    output logic                     m_axis_ts_valid,
    input  logic                     m_axis_ts_ready,

    output logic [15:0]              overflow_count,
    output logic                     overflow_pulse
);

    localparam int AW    = $clog2(TS_FIFO_DEPTH);
    localparam int REC_W = PTP_TS_WIDTH + PTP_TAG_WIDTH + 16 + 1;

    typedef enum logic {ST_IDLE, ST_FRAME} state_t;

    function automatic logic [15:0] popcount(input logic [KEEP_WIDTH-1:0] k);
        logic [15:0] n;
        n = '0;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) n = n + 16'(k[i]);
        return n;
    endfunction

    state_t                   state_q, state_d;
    logic [PTP_TS_WIDTH-1:0]  ts_q, ts_d;
    logic [PTP_TAG_WIDTH-1:0] tag_q, tag_d;
    logic [15:0]              cnt_q, cnt_d;
    logic [AW:0]              wptr_q, rptr_q;
    logic [REC_W-1:0]         mem_q [TS_FIFO_DEPTH];
    logic [15:0]              ovf_cnt_q;
    logic                     ovf_pulse_q;

    logic              fifo_full, fifo_empty, stall, accept, push_ok, drop, pop;
    logic [15:0]       beat_bytes, sum_sat;
    logic [16:0]       sum;
    logic [REC_W-1:0]  rec_d;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // Only the registered full flag gates the tlast beat, so ts_ready never reaches tready.
    assign stall = (FULL_MODE == 1) && fifo_full && s_axis_tvalid && s_axis_tlast;

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tvalid = s_axis_tvalid && !stall;
    assign s_axis_tready = m_axis_tready && !stall;

    assign accept     = s_axis_tvalid && s_axis_tready;
    assign beat_bytes = popcount(s_axis_tkeep);
    assign sum        = {1'b0, cnt_q} + {1'b0, beat_bytes};
    assign sum_sat    = sum[16] ? 16'hFFFF : sum[15:0];

    always_comb begin
        state_d = state_q;
        ts_d    = ts_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        if (accept) begin
            if (state_q == ST_IDLE) begin
                ts_d  = ptp_time;
                tag_d = s_axis_tuser[PTP_TAG_WIDTH:1];
                cnt_d = beat_bytes;
            end else begin
                cnt_d = sum_sat;
            end
            state_d = s_axis_tlast ? ST_IDLE : ST_FRAME;
        end
    end

    assign rec_d   = {ts_d, tag_d, cnt_d, s_axis_tuser[0]};
    assign push_ok = accept && s_axis_tlast && !fifo_full;
    assign drop    = accept && s_axis_tlast && fifo_full;
    assign pop     = !fifo_empty && m_axis_ts_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ts_q        <= '0;
            tag_q       <= '0;
            cnt_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            ovf_cnt_q   <= '0;
            ovf_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_d;
            tag_q       <= tag_d;
            cnt_q       <= cnt_d;
            ovf_pulse_q <= drop;
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            if (drop && ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= rec_d;
    end

    assign {m_axis_ts, m_axis_ts_tag, m_axis_ts_len, m_axis_ts_err} = mem_q[rptr_q[AW-1:0]];
    assign m_axis_ts_valid = !fifo_empty;
    assign overflow_count  = ovf_cnt_q;
    assign overflow_pulse  = ovf_pulse_q;

endmodule

// File: tb/tb_axis_eth_ptp_ts_capture.sv
// Directed bench: three builds (64-bit drop mode, 64-bit backpressure mode, 8-bit)
// sharing one stimulus bus, selected by sel.
module tb_axis_eth_ptp_ts_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tlast;
    logic [16:0] s_tuser;
    logic [95:0] ptp_time;
    logic        vld;
    logic [1:0]  sel;
    logic        m_tready;
    logic        tsr [3];

    logic        s_tvalid [3];
    logic        s_tready [3];
    logic        mtvalid  [3];
    logic        mtlast   [3];
    logic [95:0] ts_o     [3];
    logic [15:0] tag_o    [3];
    logic [15:0] len_o    [3];
    logic        err_o    [3];
    logic        tsv      [3];
    logic [15:0] ovc      [3];
    logic        ovp      [3];
    logic [63:0] mtd      [2];
    logic [7:0]  mtk      [2];
    logic [16:0] mtu      [2];
    logic [7:0]  mtd_c;
    logic        mtk_c;
    logic [16:0] mtu_c;

    int nvec = 0;
    int nerr = 0;
    int pulse_cnt = 0;
    int stall_cycles = 0;

    always #5 clk = ~clk;

    assign s_tvalid[0] = vld && (sel == 2'd0);
    assign s_tvalid[1] = vld && (sel == 2'd1);
    assign s_tvalid[2] = vld && (sel == 2'd2);

    always @(negedge clk) if (ovp[0]) pulse_cnt++;

    axis_eth_ptp_ts_capture #(.DATA_WIDTH(64), .TS_FIFO_DEPTH(4), .FULL_MODE(0)) dut_a (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid[0]),
        .s_axis_tready(s_tready[0]), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(mtd[0]), .m_axis_tkeep(mtk[0]), .m_axis_tvalid(mtvalid[0]),
        .m_axis_tready(m_tready), .m_axis_tlast(mtlast[0]), .m_axis_tuser(mtu[0]),
        .ptp_time(ptp_time),
        .m_axis_ts(ts_o[0]), .m_axis_ts_tag(tag_o[0]), .m_axis_ts_len(len_o[0]),
        .m_axis_ts_err(err_o[0]), .m_axis_ts_valid(tsv[0]), .m_axis_ts_ready(tsr[0]),
        .overflow_count(ovc[0]), .overflow_pulse(ovp[0])
    );

    axis_eth_ptp_ts_capture #(.DATA_WIDTH(64), .TS_FIFO_DEPTH(4), .FULL_MODE(1)) dut_b (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid[1]),
        .s_axis_tready(s_tready[1]), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(mtd[1]), .m_axis_tkeep(mtk[1]), .m_axis_tvalid(mtvalid[1]),
        .m_axis_tready(m_tready), .m_axis_tlast(mtlast[1]), .m_axis_tuser(mtu[1]),
        .ptp_time(ptp_time),
        .m_axis_ts(ts_o[1]), .m_axis_ts_tag(tag_o[1]), .m_axis_ts_len(len_o[1]),
        .m_axis_ts_err(err_o[1]), .m_axis_ts_valid(tsv[1]), .m_axis_ts_ready(tsr[1]),
        .overflow_count(ovc[1]), .overflow_pulse(ovp[1])
    );

    axis_eth_ptp_ts_capture #(.DATA_WIDTH(8), .TS_FIFO_DEPTH(4), .FULL_MODE(0)) dut_c (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata[7:0]), .s_axis_tkeep(s_tkeep[0]), .s_axis_tvalid(s_tvalid[2]),
        .s_axis_tready(s_tready[2]), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(mtd_c), .m_axis_tkeep(mtk_c), .m_axis_tvalid(mtvalid[2]),
        .m_axis_tready(m_tready), .m_axis_tlast(mtlast[2]), .m_axis_tuser(mtu_c),
        .ptp_time(ptp_time),
        .m_axis_ts(ts_o[2]), .m_axis_ts_tag(tag_o[2]), .m_axis_ts_len(len_o[2]),
        .m_axis_ts_err(err_o[2]), .m_axis_ts_valid(tsv[2]), .m_axis_ts_ready(tsr[2]),
        .overflow_count(ovc[2]), .overflow_pulse(ovp[2])
    );

    typedef struct {
        int          beats;
        logic [7:0]  last_keep;
        logic [15:0] tag;
        logic        err;
        logic [95:0] t0;
        logic [15:0] exp_len;
    } frame_vec_t;

    frame_vec_t vecs [5];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rec(input int d, input string nm, input logic [95:0] t,
                           input logic [15:0] tg, input logic [15:0] l, input logic e);
        check({nm, ".valid"}, 128'(tsv[d]), 128'(1'b1));
        check({nm, ".ts"},    128'(ts_o[d]), 128'(t));
        check({nm, ".tag"},   128'(tag_o[d]), 128'(tg));
        check({nm, ".len"},   128'(len_o[d]), 128'(l));
        check({nm, ".err"},   128'(err_o[d]), 128'(e));
    endtask

    // Entered and left at posedge+1.
    task automatic send_beat(input logic [7:0] keep, input logic last,
                             input logic [15:0] tg, input logic e);
        int n;
        s_tdata = {$urandom, $urandom};
        s_tkeep = keep;
        s_tlast = last;
        s_tuser = {tg, e};
        vld     = 1'b1;
        n = 0;
        #1;
        while (!s_tready[sel] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        stall_cycles += n;
        if (!s_tready[sel]) begin
            nvec++; nerr++;
            $display("FAIL beat_accept_timeout: tready stuck at 0, required 1");
        end else begin
            if (sel == 2'd2)
                check("passthru_c", {mtvalid[2], mtd_c, mtk_c, mtlast[2], mtu_c},
                      {1'b1, s_tdata[7:0], keep[0], last, s_tuser});
            else
                check("passthru", {mtvalid[sel], mtd[sel], mtk[sel], mtlast[sel], mtu[sel]},
                      {1'b1, s_tdata, keep, last, s_tuser});
            @(posedge clk); #1;
        end
        vld = 1'b0;
    endtask

    // Later beats carry a different tag / err so that holding from SOF is exercised.
    task automatic send_frame(input int beats, input logic [7:0] last_keep,
                              input logic [15:0] tg, input logic e,
                              input logic [95:0] t0, input logic gaps);
        for (int b = 0; b < beats; b++) begin
            if (gaps && (b % 100 == 50)) begin
                @(posedge clk); #1;
            end
            ptp_time = (b == 0) ? t0 : t0 + 96'(7 * b + 3);
            if (b == beats - 1) send_beat(last_keep, 1'b1, (b == 0) ? tg : ~tg, e);
            else                send_beat(8'hFF, 1'b0, (b == 0) ? tg : ~tg, ~e);
        end
        ptp_time = t0 + 96'd999;
    endtask

    initial begin
        int base;
        vecs[0] = '{8, 8'h0F, 16'h1234, 1'b0, 96'h0000_0001_0000_0000_1111_0000, 16'd60};
        vecs[1] = '{1, 8'h3F, 16'hABCD, 1'b1, 96'h0000_0002_0000_0000_2222_0000, 16'd6};
        vecs[2] = '{3, 8'hFF, 16'h0001, 1'b0, 96'h0000_0003_0000_0000_3333_0000, 16'd24};
        vecs[3] = '{2, 8'h00, 16'hFFFF, 1'b1, 96'h0000_0004_0000_0000_4444_0000, 16'd8};
        vecs[4] = '{5, 8'h01, 16'h0F0F, 1'b0, 96'h0000_0005_0000_0000_5555_0000, 16'd33};

        rst = 1'b1; vld = 1'b0; sel = 2'd0; m_tready = 1'b1;
        s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = '0; ptp_time = '0;
        for (int k = 0; k < 3; k++) tsr[k] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("reset.ts_valid", 128'(tsv[k]), 128'(1'b0));
            check("reset.ovf_count", 128'(ovc[k]), 128'(16'd0));
            check("reset.ovf_pulse", 128'(ovp[k]), 128'(1'b0));
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven single frames, records drained immediately.
        sel = 2'd0; tsr[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("pre_frame.ts_valid", 128'(tsv[0]), 128'(1'b0));
            send_frame(vecs[i].beats, vecs[i].last_keep, vecs[i].tag, vecs[i].err, vecs[i].t0, 1'b0);
            chk_rec(0, "table", vecs[i].t0, vecs[i].tag, vecs[i].exp_len, vecs[i].err);
            @(posedge clk); #1;
        end
        check("table.drained", 128'(tsv[0]), 128'(1'b0));

        // Downstream backpressure propagates, tvalid is not gated by it.
        m_tready = 1'b0; vld = 1'b1; s_tlast = 1'b0; #1;
        check("m_tready_low", {s_tready[0], mtvalid[0]}, {1'b0, 1'b1});
        vld = 1'b0; m_tready = 1'b1;
        @(posedge clk); #1;

        // Drop mode: six frames into a depth-4 FIFO with no draining.
        tsr[0] = 1'b0; base = pulse_cnt; stall_cycles = 0;
        for (int i = 0; i < 6; i++)
            send_frame(1, 8'hFF, 16'h0100 + 16'(i), 1'b0, 96'd1000 + 96'(i), 1'b0);
        @(posedge clk); #1;
        check("drop.no_stall", 128'(stall_cycles), 128'(0));
        check("drop.ovf_count", 128'(ovc[0]), 128'(16'd2));
        check("drop.pulses", 128'(pulse_cnt - base), 128'(2));
        tsr[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_rec(0, "drop_drain", 96'd1000 + 96'(i), 16'h0100 + 16'(i), 16'd8, 1'b0);
            @(posedge clk); #1;
        end
        check("drop.drained", 128'(tsv[0]), 128'(1'b0));

        // Reset in the middle of a frame.
        ptp_time = 96'd5000; send_beat(8'hFF, 1'b0, 16'h2222, 1'b0);
        ptp_time = 96'd5007; send_beat(8'hFF, 1'b0, 16'h2222, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst.ts_valid", 128'(tsv[0]), 128'(1'b0));
        check("midrst.ovf_count", 128'(ovc[0]), 128'(16'd0));
        send_frame(2, 8'hFF, 16'h3333, 1'b0, 96'd6000, 1'b0);
        chk_rec(0, "after_rst", 96'd6000, 16'h3333, 16'd16, 1'b0);
        @(posedge clk); #1;

        // Backpressure mode: fifth tlast beat held until a record is popped.
        sel = 2'd1; tsr[1] = 1'b0;
        for (int i = 0; i < 4; i++)
            send_frame(1, 8'hFF, 16'h0200 + 16'(i), 1'b0, 96'd2000 + 96'(i), 1'b0);
        ptp_time = 96'd2004;
        s_tdata = {$urandom, $urandom}; s_tkeep = 8'h0F; s_tlast = 1'b1;
        s_tuser = {16'h0204, 1'b1}; vld = 1'b1;
        repeat (3) begin
            #1;
            check("full.stalled", {s_tready[1], mtvalid[1]}, {1'b0, 1'b0});
            @(posedge clk); #1;
        end
        tsr[1] = 1'b1; #1;
        check("full.no_comb_ready", 128'(s_tready[1]), 128'(1'b0));
        chk_rec(1, "full0", 96'd2000, 16'h0200, 16'd8, 1'b0);
        @(posedge clk); #1;
        check("full.released", {s_tready[1], mtvalid[1]}, {1'b1, 1'b1});
        chk_rec(1, "full1", 96'd2001, 16'h0201, 16'd8, 1'b0);
        @(posedge clk); #1;
        vld = 1'b0;
        for (int i = 2; i < 5; i++) begin
            if (i < 4) chk_rec(1, "full_n", 96'd2000 + 96'(i), 16'h0200 + 16'(i), 16'd8, 1'b0);
            else       chk_rec(1, "full_n", 96'd2004, 16'h0204, 16'd4, 1'b1);
            @(posedge clk); #1;
        end
        check("full.drained", 128'(tsv[1]), 128'(1'b0));
        check("full.ovf_count", 128'(ovc[1]), 128'(16'd0));

        // Byte count saturation: 8200 full beats = 65600 bytes.
        sel = 2'd0;
        send_frame(8200, 8'hFF, 16'h5A5A, 1'b0, 96'd7000, 1'b0);
        chk_rec(0, "saturate", 96'd7000, 16'h5A5A, 16'hFFFF, 1'b0);
        @(posedge clk); #1;

        // 8-bit build: 1600-byte frame with idle gaps mid-frame.
        sel = 2'd2; tsr[2] = 1'b1;
        send_frame(1600, 8'h01, 16'hC0DE, 1'b1, 96'd9000, 1'b1);
        chk_rec(2, "w8_1600", 96'd9000, 16'hC0DE, 16'd1600, 1'b1);
        @(posedge clk); #1;
        check("w8.drained", 128'(tsv[2]), 128'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
